// File: rtl/window_3x3_padding.sv
// Streaming 3x3 window generator with zero padding (same-size conv, pad=1).
// One window per input pixel, centred on it; flushes itself at end of frame.
module window_3x3_padding #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned WIDTH      = 112
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic                    in_ready,
   output logic                    valid_out,
   output logic [9*DATA_WIDTH-1:0] window_out,
   output logic [31:0]             out_row,
   output logic [31:0]             out_col,
   output logic                    frame_done
);

   localparam int unsigned SrLen  = 2 * WIDTH + 3;
   localparam int unsigned NSteps = WIDTH * WIDTH + WIDTH + 1;
   localparam int unsigned SW     = $clog2(NSteps);
   localparam int unsigned CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [SW-1:0] FirstFlush = SW'(WIDTH * WIDTH);
   localparam logic [SW-1:0] LastStep   = SW'(WIDTH * WIDTH + WIDTH);
   localparam logic [SW-1:0] FirstEmit  = SW'(WIDTH + 1);
   localparam logic [CW-1:0] LastIdx    = CW'(WIDTH - 1);

   logic [DATA_WIDTH-1:0]   sr_q [SrLen];
   logic [DATA_WIDTH-1:0]   sr_d [SrLen];
   logic [SW-1:0]           step_q, step_d;
   logic [CW-1:0]           row_q, row_d, col_q, col_d;
   logic [9*DATA_WIDTH-1:0] win_q, win_d;
   logic [CW-1:0]           out_row_q, out_col_q;
   logic                    valid_q, done_q;
   logic                    beat, flush, step, emit, last_centre;

   always_comb begin
      in_ready    = (step_q < FirstFlush);
      beat        = valid_in & in_ready;
      flush       = ~in_ready;
      step        = beat | flush;
      emit        = step & (step_q >= FirstEmit);
      last_centre = (row_q == LastIdx) && (col_q == LastIdx);

      step_d = (step_q == LastStep) ? '0 : step_q + 1'b1;

      sr_d[0] = beat ? data_in : '0;
      for (int i = 1; i < SrLen; i++) begin
         sr_d[i] = sr_q[i-1];
      end

      col_d = (col_q == LastIdx) ? '0 : col_q + 1'b1;
      row_d = row_q;
      if (col_q == LastIdx) begin
         row_d = (row_q == LastIdx) ? '0 : row_q + 1'b1;
      end

      // ro/co index the window offset: 0 -> -1, 1 -> 0, 2 -> +1; taps come from the post-shift SR.
      win_d = '0;
      for (int ro = 0; ro < 3; ro++) begin
         for (int co = 0; co < 3; co++) begin
            if (!((ro == 0 && row_q == '0) || (ro == 2 && row_q == LastIdx) ||
                  (co == 0 && col_q == '0) || (co == 2 && col_q == LastIdx))) begin
               win_d[(ro*3+co)*DATA_WIDTH +: DATA_WIDTH] =
                  sr_d[2*WIDTH + 2 - ro*WIDTH - co];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SrLen; i++) begin
            sr_q[i] <= '0;
         end
         step_q    <= '0;
         row_q     <= '0;
         col_q     <= '0;
         win_q     <= '0;
         out_row_q <= '0;
         out_col_q <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         valid_q <= emit;
         done_q  <= emit & last_centre;
         if (step) begin
            for (int i = 0; i < SrLen; i++) begin
               sr_q[i] <= sr_d[i];
            end
            step_q <= step_d;
         end
         if (emit) begin
            win_q     <= win_d;
            out_row_q <= row_q;
            out_col_q <= col_q;
            row_q     <= row_d;
            col_q     <= col_d;
         end
      end
   end

   assign valid_out  = valid_q;
   assign frame_done = done_q;
   assign window_out = win_q;
   assign out_row    = {{(32-CW){1'b0}}, out_row_q};
   assign out_col    = {{(32-CW){1'b0}}, out_col_q};

endmodule

// File: tb/tb_window_3x3_padding.sv
// Directed bench for window_3x3_padding at WIDTH=4: clean, gapped, back-to-back
// and mid-frame-reset frames, checked against a coordinate-based window model.
module tb_window_3x3_padding;

   localparam int DW = 16;
   localparam int W  = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            valid_in = 1'b0;
   logic [DW-1:0]   data_in = '0;
   logic            in_ready, valid_out, frame_done;
   logic [9*DW-1:0] window_out;
   logic [31:0]     out_row, out_col;

   window_3x3_padding #(
      .DATA_WIDTH(DW),
      .WIDTH     (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .in_ready  (in_ready),
      .valid_out (valid_out),
      .window_out(window_out),
      .out_row   (out_row),
      .out_col   (out_col),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              frame;
      int              r;
      int              c;
      logic [9*DW-1:0] win;
   } tv_t;

   tv_t tbl [7];

   int checks = 0;
   int errors = 0;

   logic [9*DW-1:0] cap_win [$];
   int              cap_row [$];
   int              cap_col [$];
   logic            cap_fd  [$];
   int              beats_acc = 0;
   int              first_beat = -1;

   always @(negedge clk) begin
      if (rst_n && valid_out) begin
         if (cap_win.size() == 0) first_beat = beats_acc;
         cap_win.push_back(window_out);
         cap_row.push_back(int'(out_row));
         cap_col.push_back(int'(out_col));
         cap_fd.push_back(frame_done);
      end
   end

   task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [9*DW-1:0] pk(input int a [9]);
      logic [9*DW-1:0] v = '0;
      for (int k = 0; k < 9; k++) v[k*DW +: DW] = DW'(a[k]);
      return v;
   endfunction

   // Reference: pixel (r,c) of a frame is base + r*W + c; outside the plane is 0.
   function automatic logic [9*DW-1:0] exp_win(input int base, input int r, input int c);
      logic [9*DW-1:0] v = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (rr >= 0 && rr < W && cc >= 0 && cc < W)
               v[((dr+1)*3 + (dc+1))*DW +: DW] = DW'(base + rr*W + cc);
         end
      end
      return v;
   endfunction

   task automatic clear_cap();
      cap_win.delete();
      cap_row.delete();
      cap_col.delete();
      cap_fd.delete();
      beats_acc  = 0;
      first_beat = -1;
   endtask

   // All driver tasks start and end at a falling edge.
   task automatic send(input int d);
      int   n = 0;
      logic acc;
      do begin
         valid_in = 1'b1;
         data_in  = DW'(d);
         acc      = in_ready;
         @(posedge clk);
         if (acc) beats_acc++;
         @(negedge clk);
         n++;
      end while (!acc && n < 20);
      if (!acc) chk("send_accept", {143'b0, acc}, 144'd1);
      valid_in = 1'b0;
   endtask

   task automatic gap();
      valid_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_frame(input int base, input bit gaps, input bit junk);
      int n = 0;
      for (int p = 0; p < W*W; p++) begin
         if (gaps) repeat ($urandom_range(0, 2)) gap();
         send(base + p);
      end
      while (!in_ready && n < 12) begin
         valid_in = junk;
         data_in  = 16'hBEEF;
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      valid_in = 1'b0;
      chk("flush_len", 144'(n), 144'(W + 1));
   endtask

   task automatic check_frame(input int base, input int off);
      for (int i = 0; i < W*W; i++) begin
         if (off + i < cap_win.size()) begin
            chk($sformatf("win_b%0d_i%0d", base, i), cap_win[off+i], exp_win(base, i / W, i % W));
            chk($sformatf("row_b%0d_i%0d", base, i), 144'(cap_row[off+i]), 144'(i / W));
            chk($sformatf("col_b%0d_i%0d", base, i), 144'(cap_col[off+i]), 144'(i % W));
            chk($sformatf("fd_b%0d_i%0d", base, i), 144'(cap_fd[off+i]), 144'(i == W*W-1));
         end else begin
            chk($sformatf("missing_b%0d_i%0d", base, i), 144'(cap_win.size()), 144'(off + i + 1));
         end
      end
   endtask

   task automatic apply_table(input int max_frame);
      for (int t = 0; t < 7; t++) begin
         int idx = tbl[t].frame * W*W + tbl[t].r * W + tbl[t].c;
         if (tbl[t].frame <= max_frame) begin
            if (idx < cap_win.size())
               chk($sformatf("tbl%0d_f%0d_r%0d_c%0d", t, tbl[t].frame, tbl[t].r, tbl[t].c),
                   cap_win[idx], tbl[t].win);
            else
               chk($sformatf("tbl%0d_missing", t), 144'(cap_win.size()), 144'(idx + 1));
         end
      end
   endtask

   initial begin
      tbl[0] = '{0, 0, 0, pk('{0, 0, 0, 0, 1, 2, 0, 5, 6})};
      tbl[1] = '{0, 1, 1, pk('{1, 2, 3, 5, 6, 7, 9, 10, 11})};
      tbl[2] = '{0, 3, 3, pk('{11, 12, 0, 15, 16, 0, 0, 0, 0})};
      tbl[3] = '{0, 0, 3, pk('{0, 0, 0, 3, 4, 0, 7, 8, 0})};
      tbl[4] = '{0, 3, 0, pk('{0, 9, 10, 0, 13, 14, 0, 0, 0})};
      tbl[5] = '{0, 2, 1, pk('{5, 6, 7, 9, 10, 11, 13, 14, 15})};
      tbl[6] = '{1, 0, 0, pk('{0, 0, 0, 0, 101, 102, 0, 105, 106})};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 144'(in_ready), 144'd1);
      chk("rst_valid_out", 144'(valid_out), 144'd0);
      chk("rst_window", window_out, 144'd0);
      chk("rst_row", 144'(out_row), 144'd0);
      chk("rst_col", 144'(out_col), 144'd0);
      chk("rst_frame_done", 144'(frame_done), 144'd0);
      @(negedge clk);

      // Clean frame.
      clear_cap();
      run_frame(1, 1'b0, 1'b0);
      repeat (2) gap();
      chk("clean_count", 144'(cap_win.size()), 144'(W*W));
      chk("clean_first_after_beat", 144'(first_beat), 144'(W + 2));
      check_frame(1, 0);
      apply_table(0);

      // Random gaps and valid_in held high during flush.
      clear_cap();
      run_frame(1, 1'b1, 1'b1);
      repeat (2) gap();
      chk("gap_count", 144'(cap_win.size()), 144'(W*W));
      check_frame(1, 0);
      apply_table(0);

      // Back-to-back frames.
      clear_cap();
      run_frame(1, 1'b0, 1'b0);
      run_frame(101, 1'b0, 1'b0);
      repeat (2) gap();
      chk("b2b_count", 144'(cap_win.size()), 144'(2*W*W));
      check_frame(1, 0);
      check_frame(101, W*W);
      apply_table(1);

      // Reset mid-frame after pixel 9, then restart.
      clear_cap();
      for (int p = 1; p <= 9; p++) send(p);
      chk("pre_rst_valid", 144'(valid_out), 144'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid_out", 144'(valid_out), 144'd0);
      chk("midrst_window", window_out, 144'd0);
      chk("midrst_row", 144'(out_row), 144'd0);
      chk("midrst_col", 144'(out_col), 144'd0);
      @(negedge clk);
      rst_n = 1'b1;
      clear_cap();
      @(negedge clk);
      run_frame(1, 1'b0, 1'b0);
      repeat (2) gap();
      chk("restart_count", 144'(cap_win.size()), 144'(W*W));
      check_frame(1, 0);
      apply_table(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
